// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Turns single-beat CPU load/store requests into APB setup/access transfers.
// It also steers write lanes, extracts and extends read data, faults misaligned
// or illegal-size requests without touching the bus, and bounds the ACCESS
// phase with a timeout so a hung slave cannot stall the CPU.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request; one forced gap after every mem_done
// SETUP  | APB setup phase: psel=1, penable=0, always exactly one cycle
// ACCESS | APB access phase: psel=1, penable=1, waiting on pready/timeout
// FAULT  | rejected request: no bus activity, completes with an error
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_we,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_done,
    output logic                  mem_err,
    output logic [ADDR_WIDTH-1:0] fault_addr,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  perr
);

    // The down-counter only ever holds TIMEOUT_CYCLES-1 .. 0.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_BAD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Request fields captured at acceptance; the CPU side may change afterwards.
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [1:0]            req_size_q, req_size_d;
    logic                  req_unsigned_q, req_unsigned_d;

    logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;

    logic [ADDR_WIDTH-1:0] paddr_d;
    logic [DATA_WIDTH-1:0] pdata_d;
    logic                  psel_d, penable_d, pwrite_d;
    logic [3:0]            pstb_d;
    logic                  done_d, err_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [ADDR_WIDTH-1:0] fault_addr_d;

    logic                  req_bad;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [3:0]            wr_strb;
    logic [4:0]            rd_lane_off;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] rd_data;

    // Classify the live request: illegal size or misaligned for its size.
    always_comb begin
        req_bad = 1'b0;
        case (mem_size)
            SIZE_HALF: req_bad = mem_addr[0];
            SIZE_WORD: req_bad = (mem_addr[1:0] != 2'b00);
            SIZE_BAD:  req_bad = 1'b1;
            default:   req_bad = 1'b0;
        endcase
    end

    // Write lane steering from the live request (registered on acceptance).
    always_comb begin
        wr_data = mem_wdata;
        wr_strb = 4'b1111;
        case (mem_size)
            SIZE_BYTE: begin
                wr_data = {4{mem_wdata[7:0]}};
                wr_strb = 4'b0001 << mem_addr[1:0];
            end
            SIZE_HALF: begin
                wr_data = {2{mem_wdata[15:0]}};
                wr_strb = 4'b0011 << mem_addr[1:0];
            end
            default: ;
        endcase
        if (!mem_we) begin
            wr_strb = 4'b0000;
        end
    end

    // Read extraction and extension using the captured size/offset/signedness.
    // Half accesses are always aligned here, so only addr[1] picks the half.
    always_comb begin
        rd_lane_off = {req_addr_q[1:0], 3'b000};
        rd_byte     = prdata[rd_lane_off +: 8];
        rd_half     = prdata[{req_addr_q[1], 4'b0000} +: 16];
        rd_data     = prdata;
        case (req_size_q)
            SIZE_BYTE: rd_data = req_unsigned_q ? {24'd0, rd_byte}
                                                : {{24{rd_byte[7]}}, rd_byte};
            SIZE_HALF: rd_data = req_unsigned_q ? {16'd0, rd_half}
                                                : {{16{rd_half[15]}}, rd_half};
            default:   rd_data = prdata;
        endcase
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d        = state_q;
        req_addr_d     = req_addr_q;
        req_size_d     = req_size_q;
        req_unsigned_d = req_unsigned_q;
        tmo_cnt_d      = tmo_cnt_q;
        paddr_d        = paddr;
        pdata_d        = pdata;
        psel_d         = psel;
        penable_d      = penable;
        pwrite_d       = pwrite;
        pstb_d         = pstb;
        done_d         = 1'b0;
        err_d          = 1'b0;
        rdata_d        = mem_rdata;
        fault_addr_d   = fault_addr;

        case (state_q)
            IDLE: begin
                // mem_done gating keeps a still-held request from re-issuing.
                if (mem_req && !mem_done) begin
                    req_addr_d     = mem_addr;
                    req_size_d     = mem_size;
                    req_unsigned_d = mem_unsigned;
                    if (req_bad) begin
                        state_d = FAULT;
                    end else begin
                        state_d  = SETUP;
                        psel_d   = 1'b1;
                        penable_d = 1'b0;
                        paddr_d  = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                        pdata_d  = wr_data;
                        pstb_d   = wr_strb;
                        pwrite_d = mem_we;
                    end
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                tmo_cnt_d = TMO_LOAD;
            end

            ACCESS: begin
                if (pready) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = perr;
                    rdata_d   = perr ? '0 : rd_data;
                    if (perr) begin
                        fault_addr_d = req_addr_q;
                    end
                end else if (tmo_cnt_q == '0) begin
                    // Slave never answered: abandon the transfer with an error.
                    state_d      = IDLE;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    done_d       = 1'b1;
                    err_d        = 1'b1;
                    rdata_d      = '0;
                    fault_addr_d = req_addr_q;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
                end
            end

            FAULT: begin
                state_d      = IDLE;
                done_d       = 1'b1;
                err_d        = 1'b1;
                rdata_d      = '0;
                fault_addr_d = req_addr_q;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered bus/CPU outputs, captured request and timeout counter.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            req_addr_q     <= '0;
            req_size_q     <= 2'd0;
            req_unsigned_q <= 1'b0;
            tmo_cnt_q      <= '0;
            paddr          <= '0;
            pdata          <= '0;
            psel           <= 1'b0;
            penable        <= 1'b0;
            pwrite         <= 1'b0;
            pstb           <= 4'b0000;
            mem_done       <= 1'b0;
            mem_err        <= 1'b0;
            mem_rdata      <= '0;
            fault_addr     <= '0;
        end else begin
            req_addr_q     <= req_addr_d;
            req_size_q     <= req_size_d;
            req_unsigned_q <= req_unsigned_d;
            tmo_cnt_q      <= tmo_cnt_d;
            paddr          <= paddr_d;
            pdata          <= pdata_d;
            psel           <= psel_d;
            penable        <= penable_d;
            pwrite         <= pwrite_d;
            pstb           <= pstb_d;
            mem_done       <= done_d;
            mem_err        <= err_d;
            mem_rdata      <= rdata_d;
            fault_addr     <= fault_addr_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Directed transactions against apb_master_bridge. A timeline model, indexed by
// clock edges since acceptance, states what the bus and CPU outputs must be;
// a single compare process checks them every cycle, and each directed case
// also pins a few hand-computed literals.
module tb_apb_master_bridge;

    localparam int AW  = 32;
    localparam int TMO = 4;

    logic          pclk = 1'b0;
    logic          rst;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [1:0]    mem_size;
    logic          mem_unsigned;
    logic [31:0]   mem_rdata;
    logic          mem_done;
    logic          mem_err;
    logic [AW-1:0] fault_addr;
    logic [AW-1:0] paddr;
    logic [31:0]   pdata;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [3:0]    pstb;
    logic [31:0]   prdata;
    logic          pready;
    logic          perr;

    apb_master_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_size    (mem_size),
        .mem_unsigned(mem_unsigned),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .mem_err     (mem_err),
        .fault_addr  (fault_addr),
        .paddr       (paddr),
        .pdata       (pdata),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pstb        (pstb),
        .prdata      (prdata),
        .pready      (pready),
        .perr        (perr)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- specification-level model ----------------
    function automatic bit model_fault(input logic [31:0] addr, input int size);
        if (size == 3) return 1'b1;
        if (size == 1) return addr[0];
        if (size == 2) return addr[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_pdata(input int size, input logic [31:0] w);
        if (size == 0) return {4{w[7:0]}};
        if (size == 1) return {2{w[15:0]}};
        return w;
    endfunction

    function automatic logic [3:0] model_pstb(input int size, input int b, input bit we);
        if (!we) return 4'b0000;
        if (size == 0) return 4'(1 << b);
        if (size == 1) return 4'(3 << b);
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_load(input int size, input int b,
                                               input logic [31:0] d, input bit uns);
        longint v;
        int     nbits;
        if (size == 2) return d;
        nbits = (size == 0) ? 8 : 16;
        v = (d >> (8 * b)) & ((1 << nbits) - 1);
        if (!uns && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
        return v[31:0];
    endfunction

    // ---------------- transaction timeline ----------------
    bit          txn_active = 1'b0;
    int          k = 0;
    logic [31:0] t_addr, t_wdata, t_prdata;
    int          t_size, t_wait, t_acc, done_k;
    bit          t_we, t_uns, t_perr, t_noise, t_fault, t_timeout, t_corrupt;
    logic [31:0] exp_fault_addr = '0;
    bit          exp_psel, exp_pen, exp_err;

    // observations for literal pins
    int          psel_cycles, pen_cycles, obs_done_k, done_pulses = 0;
    logic [31:0] obs_rdata, obs_paddr, obs_pdata;
    logic [3:0]  obs_pstb;
    logic        obs_err, obs_pwrite;

    // Slave and CPU-side timeline: edge counting and pready/perr driving.
    always @(posedge pclk) begin
        if (txn_active) k++;
        #1;
        if (txn_active) begin
            pready = !t_fault && (k == t_wait + 1);
            perr   = pready ? t_perr : t_noise;
            if (t_corrupt && k == 0) begin
                mem_addr     = ~t_addr;
                mem_size     = 2'd2;
                mem_unsigned = ~t_uns;
            end
            if (k == done_k + 1) begin
                mem_req    = 1'b0;
                pready     = 1'b0;
                perr       = 1'b0;
                txn_active = 1'b0;
            end
        end
    end

    // Compare process: checks DUT outputs against the timeline every cycle.
    always @(negedge pclk) begin
        if (txn_active && k >= 0) begin
            psel_cycles += int'(psel);
            pen_cycles  += int'(penable);
            if (psel) begin
                obs_paddr  = paddr;
                obs_pstb   = pstb;
                obs_pdata  = pdata;
                obs_pwrite = pwrite;
            end
        end
        if (mem_done) begin
            done_pulses++;
            obs_rdata  = mem_rdata;
            obs_err    = mem_err;
            obs_done_k = k;
        end
        if (!txn_active || k < 0) begin
            check("idle_psel", psel, 0);
            check("idle_penable", penable, 0);
            check("idle_done", mem_done, 0);
        end else begin
            exp_psel = !t_fault && k <= t_acc;
            exp_pen  = !t_fault && k >= 1 && k <= t_acc;
            check("psel", psel, exp_psel);
            check("penable", penable, exp_pen);
            if (exp_psel) begin
                check("paddr", paddr, {t_addr[31:2], 2'b00});
                check("pwrite", pwrite, t_we);
                check("pstb", pstb, model_pstb(t_size, int'(t_addr[1:0]), t_we));
                if (t_we) check("pdata", pdata, model_pdata(t_size, t_wdata));
            end
            check("done", mem_done, k == done_k);
            if (k == done_k) begin
                exp_err = t_fault || t_timeout || t_perr;
                check("err", mem_err, exp_err);
                if (exp_err) exp_fault_addr = t_addr;
                if (!t_fault)
                    check("rdata", mem_rdata,
                          exp_err ? 32'h0 : model_load(t_size, int'(t_addr[1:0]), t_prdata, t_uns));
            end
        end
        check("fault_addr", fault_addr, exp_fault_addr);
    end

    task automatic start_txn(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] prd, input int size, input bit we,
                             input bit uns, input int wt, input bit perr_v,
                             input bit noise, input bit corrupt);
        @(posedge pclk);
        #3;
        t_addr = addr; t_wdata = wdata; t_prdata = prd; t_size = size;
        t_we = we; t_uns = uns; t_wait = wt; t_perr = perr_v; t_noise = noise;
        t_corrupt = corrupt;
        t_fault   = model_fault(addr, size);
        t_timeout = !t_fault && (wt >= TMO);
        t_acc     = t_timeout ? TMO : wt + 1;
        done_k    = t_fault ? 1 : t_acc + 1;
        psel_cycles = 0; pen_cycles = 0; obs_done_k = -1;
        mem_addr = addr; mem_wdata = wdata; mem_we = we;
        mem_size = size[1:0]; mem_unsigned = uns; prdata = prd;
        k = -1;
        txn_active = 1'b1;
        mem_req = 1'b1;
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] prd, input int size, input bit we,
                           input bit uns, input int wt, input bit perr_v,
                           input bit noise, input bit corrupt);
        start_txn(addr, wdata, prd, size, we, uns, wt, perr_v, noise, corrupt);
        for (int i = 0; i < 64 && txn_active; i++) @(posedge pclk);
        #3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int done_before;

    initial begin
        rst = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_wdata = '0; mem_we = 1'b0;
        mem_size = 2'd0; mem_unsigned = 1'b0; prdata = '0; pready = 1'b0; perr = 1'b0;
        repeat (3) @(posedge pclk);
        #3;
        check("reset_paddr", paddr, 0);
        check("reset_pdata", pdata, 0);
        check("reset_pstb", pstb, 0);
        check("reset_pwrite", pwrite, 0);
        check("reset_rdata", mem_rdata, 0);
        check("reset_fault_addr", fault_addr, 0);
        rst = 1'b0;
        repeat (2) @(posedge pclk);

        // word load, zero-wait slave
        run_txn(32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 2, 0, 0, 0, 0, 0, 0);
        check("t1_rdata", obs_rdata, 32'hDEAD_BEEF);
        check("t1_err", obs_err, 0);
        check("t1_psel_cycles", psel_cycles, 2);
        check("t1_pen_cycles", pen_cycles, 1);
        check("t1_paddr", obs_paddr, 32'h8000_0004);
        check("t1_pstb", obs_pstb, 4'b0000);
        check("t1_done_edge", obs_done_k, 2);

        // signed byte load; request fields scrambled after acceptance
        run_txn(32'h8000_0003, 32'h0, 32'h8011_2233, 0, 0, 0, 0, 0, 0, 1);
        check("t2_rdata_signed", obs_rdata, 32'hFFFF_FF80);
        run_txn(32'h8000_0003, 32'h0, 32'h8011_2233, 0, 0, 1, 0, 0, 0, 0);
        check("t3_rdata_unsigned", obs_rdata, 32'h0000_0080);

        // half store, one wait state
        run_txn(32'h1000_0002, 32'h0000_1234, 32'h0, 1, 1, 0, 1, 0, 0, 0);
        check("t4_pwrite", obs_pwrite, 1);
        check("t4_pstb", obs_pstb, 4'b1100);
        check("t4_pdata", obs_pdata, 32'h1234_1234);
        check("t4_paddr", obs_paddr, 32'h1000_0000);

        // misaligned word load
        run_txn(32'h8000_0002, 32'h0, 32'h1111_1111, 2, 0, 0, 0, 0, 0, 0);
        check("t5_psel_cycles", psel_cycles, 0);
        check("t5_done_edge", obs_done_k, 1);
        check("t5_err", obs_err, 1);
        check("t5_fault_addr", fault_addr, 32'h8000_0002);

        // hung slave with perr noise while pready is low
        run_txn(32'h2000_0010, 32'h0, 32'hA5A5_A5A5, 2, 0, 0, 10, 0, 1, 0);
        check("t6_pen_cycles", pen_cycles, 4);
        check("t6_rdata", obs_rdata, 32'h0);
        check("t6_err", obs_err, 1);
        check("t6_fault_addr", fault_addr, 32'h2000_0010);

        // slave error at unmapped address
        run_txn(32'h3000_0000, 32'h0, 32'h0000_0055, 2, 0, 0, 0, 1, 0, 0);
        check("t7_err", obs_err, 1);
        check("t7_rdata", obs_rdata, 32'h0);
        check("t7_fault_addr", fault_addr, 32'h3000_0000);

        // byte store at lane 1
        run_txn(32'h2000_0001, 32'h0000_00AB, 32'h0, 0, 1, 0, 0, 0, 0, 0);
        check("t8_pstb", obs_pstb, 4'b0010);
        check("t8_pdata", obs_pdata, 32'hABAB_ABAB);
        check("t8_err", obs_err, 0);

        // signed half load, slave answers in the last cycle before timeout
        run_txn(32'h4000_0002, 32'h0, 32'h8001_1234, 1, 0, 0, TMO - 1, 0, 0, 0);
        check("t9_rdata", obs_rdata, 32'hFFFF_8001);
        check("t9_err", obs_err, 0);
        check("t9_pen_cycles", pen_cycles, 4);

        // illegal size
        run_txn(32'h5000_0000, 32'h0, 32'h0, 3, 0, 0, 0, 0, 0, 0);
        check("t10_psel_cycles", psel_cycles, 0);
        check("t10_fault_addr", fault_addr, 32'h5000_0000);

        // word store, two wait states
        run_txn(32'h5000_0008, 32'hCAFE_F00D, 32'h0, 2, 1, 0, 2, 0, 0, 0);
        check("t11_pstb", obs_pstb, 4'b1111);
        check("t11_pdata", obs_pdata, 32'hCAFE_F00D);
        check("t11_pen_cycles", pen_cycles, 3);

        // reset during ACCESS aborts without a completion
        start_txn(32'h6000_0000, 32'h0, 32'h1234_5678, 2, 0, 0, 3, 0, 0, 0);
        repeat (3) @(posedge pclk);
        #3;
        check("t12_pre_rst_penable", penable, 1);
        done_before = done_pulses;
        rst = 1'b1; txn_active = 1'b0; mem_req = 1'b0; pready = 1'b0;
        exp_fault_addr = '0;
        #1;
        check("t12_rst_psel", psel, 0);
        check("t12_rst_penable", penable, 0);
        repeat (2) @(posedge pclk);
        #3;
        rst = 1'b0;
        repeat (4) @(posedge pclk);
        #3;
        check("t12_no_done", done_pulses, done_before);
        check("t12_paddr", paddr, 0);
        check("t12_rdata", mem_rdata, 0);
        check("t12_fault_addr", fault_addr, 0);

        // recovery after reset
        run_txn(32'h7000_000C, 32'h0, 32'h0BAD_F00D, 2, 0, 0, 0, 0, 0, 0);
        check("t13_rdata", obs_rdata, 32'h0BAD_F00D);

        repeat (2) @(posedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
